pn_edge_detect: RTL and testbench



---
 rtl/pn_detect_pkg.sv | 22 ++
 rtl/pn_edge_cell.sv | 80 ++++++++
 rtl/pn_edge_detect.sv | 48 ++++
 tb/tb_pn_edge_detect.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_detect_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
// Default, limit and counter-width definitions used by top and cell.
package pn_detect_pkg;

  localparam int PN_SYNC_STAGES_DEF = 2;
  localparam int PN_FILTER_LEN_DEF  = 1;
  localparam int PN_SYNC_MAX        = 4;
  localparam int PN_FILTER_MAX      = 255;

  typedef struct packed {
    logic p;
    logic n;
    logic lvl;
  } pn_evt_t;

  function automatic int pn_cnt_w(input int len);
    int w;
    w = $clog2(len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pn_edge_cell.sv
// One channel: synchronizer chain, deviation filter and pulse generator.
// All state is cleared by a synchronous active-low reset.
module pn_edge_cell
  import pn_detect_pkg::*;
#(
  parameter int SYNC_STAGES = PN_SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = PN_FILTER_LEN_DEF
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    cin_i,
  output pn_evt_t evt_o
);

  localparam int CW = pn_cnt_w(FILTER_LEN);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic sync;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync = cin_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= (sync_q << 1) | SYNC_STAGES'(cin_i);
      end
    end

    assign sync = sync_q[SYNC_STAGES-1];
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lvl_q;
  logic          lvl_d;
  logic          p_q;
  logic          p_d;
  logic          n_q;
  logic          n_d;

  // A deviation must persist FILTER_LEN samples; any match restarts it.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    p_d   = 1'b0;
    n_d   = 1'b0;
    if (sync != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d = sync;
        p_d   = sync;
        n_d   = ~sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
      p_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      p_q   <= p_d;
      n_q   <= n_d;
    end
  end

  assign evt_o.p   = p_q;
  assign evt_o.n   = n_q;
  assign evt_o.lvl = lvl_q;

endmodule

// File: rtl/pn_edge_detect.sv
// Multi-channel positive/negative edge detector.
// Slices ports per channel and rejects out-of-range parameters.
module pn_edge_detect
  import pn_detect_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = PN_SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = PN_FILTER_LEN_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] Cin,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] Lvl
);

  if (WIDTH < 1) begin : g_bad_width
    $error("pn_edge_detect: WIDTH must be at least 1");
  end

  if (SYNC_STAGES < 0 || SYNC_STAGES > PN_SYNC_MAX) begin : g_bad_sync
    $error("pn_edge_detect: SYNC_STAGES out of range 0..4");
  end

  if (FILTER_LEN < 1 || FILTER_LEN > PN_FILTER_MAX) begin : g_bad_filt
    $error("pn_edge_detect: FILTER_LEN out of range 1..255");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pn_evt_t evt;

    pn_edge_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_cell (
      .clk_i  (Clk),
      .rst_ni (Rst_n),
      .cin_i  (Cin[i]),
      .evt_o  (evt)
    );

    assign P[i]   = evt.p;
    assign N[i]   = evt.n;
    assign Lvl[i] = evt.lvl;
  end

endmodule

// File: tb/tb_pn_edge_detect.sv
// Bench for pn_edge_detect: three configurations share clock and reset.
// A queue-based channel model supplies expected P/N/Lvl every cycle.
module tb_pn_edge_detect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] cin_all = '0;

  logic [3:0] pa, na, la;
  logic [0:0] pb, nb, lb;
  logic [0:0] pc, nc, lc;

  always #5 clk = ~clk;

  pn_edge_detect #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(1)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .Cin(cin_all[3:0]),
    .P(pa), .N(na), .Lvl(la));

  pn_edge_detect #(.WIDTH(1), .SYNC_STAGES(2), .FILTER_LEN(4)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Cin(cin_all[4:4]),
    .P(pb), .N(nb), .Lvl(lb));

  pn_edge_detect #(.WIDTH(1), .SYNC_STAGES(0), .FILTER_LEN(1)) dut_c (
    .Clk(clk), .Rst_n(rst_n), .Cin(cin_all[5:5]),
    .P(pc), .N(nc), .Lvl(lc));

  wire [5:0] p_all = {pc, pb, pa};
  wire [5:0] n_all = {nc, nb, na};
  wire [5:0] l_all = {lc, lb, la};
  wire [17:0] obs = {p_all, n_all, l_all};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per channel, sync = input delayed S edges;
  // a level is accepted once the last F sync samples all differ.
  int ms[6] = '{2, 2, 2, 2, 2, 0};
  int mf[6] = '{1, 1, 1, 1, 4, 1};
  bit cq[6][$];
  bit sq[6][$];
  bit ml[6];
  logic [5:0] exp_p = '0;
  logic [5:0] exp_n = '0;
  logic [5:0] exp_l = '0;
  wire [17:0] expv = {exp_p, exp_n, exp_l};

  always @(posedge clk) begin : model
    bit cv;
    bit sv;
    bit all;
    for (int c = 0; c < 6; c++) begin
      cv = cin_all[c];
      if (!rst_n) begin
        cq[c] = '{0, 0, 0, 0};
        sq[c].delete();
        ml[c] = 0;
        exp_p[c] = 0;
        exp_n[c] = 0;
        exp_l[c] = 0;
      end else begin
        sv = (ms[c] == 0) ? cv : cq[c][ms[c]-1];
        cq[c].push_front(cv);
        void'(cq[c].pop_back());
        exp_p[c] = 0;
        exp_n[c] = 0;
        sq[c].push_back(sv);
        if (sq[c].size() > mf[c]) void'(sq[c].pop_front());
        all = (sq[c].size() == mf[c]);
        for (int k = 0; k < sq[c].size(); k++)
          if (sq[c][k] == ml[c]) all = 0;
        if (all) begin
          ml[c] = sv;
          exp_p[c] = sv;
          exp_n[c] = !sv;
          sq[c].delete();
        end
        exp_l[c] = ml[c];
      end
    end
  end

  task automatic tick(input logic [5:0] v, input logic r);
    @(negedge clk);
    cin_all = v;
    rst_n = r;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) tick(6'h00, 1'b1);
  endtask

  task automatic test_reset();
    int pc0, pc4, pc5, np0;
    pc0 = -1; pc4 = -1; pc5 = -1; np0 = 0;
    for (int i = 0; i < 3; i++) begin
      tick(6'h3F, 1'b0);
      n_cmp++;
      if (obs !== 18'h0) begin
        n_bad++;
        $display("FAIL reset_hold cyc %0d: got %h want 0", i, obs);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(6'h3F, 1'b1);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset_rel cyc %0d: got %h want %h", i, obs, expv);
      end
      if (p_all[0]) begin np0++; if (pc0 < 0) pc0 = i; end
      if (p_all[4] && pc4 < 0) pc4 = i;
      if (p_all[5] && pc5 < 0) pc5 = i;
    end
    n_cmp++;
    if (pc0 !== 2 || np0 !== 1) begin
      n_bad++;
      $display("FAIL reset_p_a: at %0d cnt %0d want at 2 cnt 1", pc0, np0);
    end
    n_cmp++;
    if (pc4 !== 5 || pc5 !== 0) begin
      n_bad++;
      $display("FAIL reset_p_bc: b %0d c %0d want 5 0", pc4, pc5);
    end
  endtask

  task automatic test_toggle();
    int np, nn, ov;
    logic b;
    np = 0; nn = 0; ov = 0;
    settle();
    for (int i = 0; i < 32; i++) begin
      b = ((i / 2) % 2) == 1;
      tick({5'b0, b}, 1'b1);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL toggle cyc %0d: got %h want %h", i, obs, expv);
      end
      if (p_all[0]) np++;
      if (n_all[0]) nn++;
      if ((p_all & n_all) != 0) ov++;
    end
    n_cmp++;
    if (np !== 7 || nn !== 7 || ov !== 0) begin
      n_bad++;
      $display("FAIL toggle_cnt: p %0d n %0d both %0d want 7 7 0", np, nn, ov);
    end
  endtask

  task automatic test_filter();
    int np, nn, pat, nat;
    settle();
    np = 0;
    for (int i = 0; i < 15; i++) begin
      tick((i < 3) ? 6'h10 : 6'h00, 1'b1);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL glitch cyc %0d: got %h want %h", i, obs, expv);
      end
      if (p_all[4] || l_all[4]) np++;
    end
    n_cmp++;
    if (np !== 0) begin
      n_bad++;
      $display("FAIL glitch_quiet: got %0d events want 0", np);
    end
    np = 0; nn = 0; pat = -1; nat = -1;
    for (int i = 0; i < 16; i++) begin
      tick((i < 4) ? 6'h10 : 6'h00, 1'b1);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL filt4 cyc %0d: got %h want %h", i, obs, expv);
      end
      if (p_all[4]) begin np++; pat = i; end
      if (n_all[4]) begin nn++; nat = i; end
    end
    n_cmp++;
    if (np !== 1 || pat !== 5 || nn !== 1 || nat !== 9) begin
      n_bad++;
      $display("FAIL filt4_pulse: p %0d@%0d n %0d@%0d want 1@5 1@9",
               np, pat, nn, nat);
    end
  endtask

  task automatic test_sync0();
    logic b;
    settle();
    for (int i = 0; i < 16; i++) begin
      b = (i % 2) == 0;
      tick({b, 5'b0}, 1'b1);
      n_cmp++;
      if (p_all[5] !== b || n_all[5] !== !b || obs !== expv) begin
        n_bad++;
        $display("FAIL sync0 cyc %0d: p %b n %b want p %b n %b",
                 i, p_all[5], n_all[5], b, !b);
      end
    end
  endtask

  task automatic test_multichannel();
    settle();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 11; i++) begin
        tick((s == 0) ? 6'h05 : 6'h0A, 1'b1);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL multi s%0d cyc %0d: got %h want %h", s, i, obs, expv);
        end
        if (i == 2) begin
          n_cmp++;
          if (pa !== ((s == 0) ? 4'h5 : 4'hA) ||
              na !== ((s == 0) ? 4'h0 : 4'h5)) begin
            n_bad++;
            $display("FAIL multi_step s%0d: p %b n %b", s, pa, na);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int np;
    for (int v = 0; v < 2; v++) begin
      settle();
      np = 0;
      tick(6'h01, 1'b1);
      tick(6'h01, 1'b1);
      tick((v == 0) ? 6'h01 : 6'h00, 1'b0);
      n_cmp++;
      if (pa[0] !== 1'b0 || la[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_rst v%0d: p %b lvl %b want 0 0", v, pa[0], la[0]);
      end
      for (int i = 0; i < 8; i++) begin
        tick((v == 0) ? 6'h01 : 6'h00, 1'b1);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL mid_rel v%0d cyc %0d: got %h want %h",
                   v, i, obs, expv);
        end
        if (pa[0]) np++;
      end
      n_cmp++;
      if (np !== ((v == 0) ? 1 : 0)) begin
        n_bad++;
        $display("FAIL mid_cnt v%0d: got %0d pulses want %0d",
                 v, np, (v == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    logic r;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(39) != 0);
      tick(6'($urandom), r);
      n_cmp++;
      if (obs !== expv || (p_all & n_all) != 0) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_filter();
    test_sync0();
    test_multichannel();
    test_reset_mid_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
